// File: rtl/axi4_lite_slave_mem_if_if.sv
// rtl/axi4_lite_slave_mem_if_if.sv - AXI4-Lite bus bundle for the slave memory front end
//
// Purpose: groups the five AXI4-Lite channels (AR, R, AW, W, B) into one interface.
// Ports (per channel):
//   ar: ar_valid, ar_ready, ar_addr
//   r : r_valid, r_ready, r_data, r_resp
//   aw: aw_valid, aw_ready, aw_addr
//   w : w_valid, w_ready, w_data, w_strb
//   b : b_valid, b_ready, b_resp
// Modports: master (drives requests, accepts responses), slave (the reverse).
interface axi4_lite_slave_mem_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      ar_valid;
    logic                      ar_ready;
    logic [ADDR_WIDTH-1:0]     ar_addr;

    logic                      r_valid;
    logic                      r_ready;
    logic [DATA_WIDTH-1:0]     r_data;
    logic [1:0]                r_resp;

    logic                      aw_valid;
    logic                      aw_ready;
    logic [ADDR_WIDTH-1:0]     aw_addr;

    logic                      w_valid;
    logic                      w_ready;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;

    logic                      b_valid;
    logic                      b_ready;
    logic [1:0]                b_resp;

    modport master (
        output ar_valid, ar_addr, input  ar_ready,
        input  r_valid, r_data, r_resp, output r_ready,
        output aw_valid, aw_addr, input  aw_ready,
        output w_valid, w_data, w_strb, input  w_ready,
        input  b_valid, b_resp, output b_ready
    );

    modport slave (
        input  ar_valid, ar_addr, output ar_ready,
        output r_valid, r_data, r_resp, input  r_ready,
        input  aw_valid, aw_addr, output aw_ready,
        input  w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input  b_ready
    );
endinterface

// File: rtl/axi4_lite_slave_mem_if.sv
// rtl/axi4_lite_slave_mem_if.sv - AXI4-Lite slave front end for a synchronous memory port
//
// Purpose: converts AXI4-Lite reads and writes into single-cycle memory strobes.
//   Reads wait RD_LATENCY cycles for memory data; AW and W are accepted independently
//   in any order; misaligned addresses get SLVERR without touching memory.
//   Read and write engines are fully independent.
// Ports:
//   iClock   clock, rising edge
//   iReset   asynchronous active-low reset
//   axi      AXI4-Lite slave bus (interface, slave modport)
//   oRdEn    one-cycle memory read strobe, oRdAddr latched read address
//   iRdData  read data / iRdResp read status, valid RD_LATENCY cycles after oRdEn
//   oWrEn    one-cycle memory write strobe with oWrAddr/oWrData/oWrMask
//   iWrResp  write status, sampled in the oWrEn cycle
module axi4_lite_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                      iClock,
    input  logic                      iReset,
    axi4_lite_slave_mem_if_if.slave   axi,
    output logic                      oRdEn,
    output logic [ADDR_WIDTH-1:0]     oRdAddr,
    input  logic [DATA_WIDTH-1:0]     iRdData,
    input  logic [1:0]                iRdResp,
    output logic                      oWrEn,
    output logic [ADDR_WIDTH-1:0]     oWrAddr,
    output logic [DATA_WIDTH-1:0]     oWrData,
    output logic [DATA_WIDTH/8-1:0]   oWrMask,
    input  logic [1:0]                iWrResp
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = 5;
    localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any byte-offset bit set means the access does not start on a word boundary.
    function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
        return |(addr & OFFSET_MASK);
    endfunction

    // ---------------------------------------------------------------- read engine
    typedef enum logic [1:0] {RD_IDLE, RD_MEM, RD_WAIT, RD_RESP} rd_state_t;

    rd_state_t               rd_state, rd_state_n;
    logic [ADDR_WIDTH-1:0]   rd_addr, rd_addr_n;
    logic [CNT_WIDTH-1:0]    rd_cnt, rd_cnt_n;
    logic [DATA_WIDTH-1:0]   rd_data, rd_data_n;
    logic [1:0]              rd_resp, rd_resp_n;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rd_state <= RD_IDLE;
            rd_addr  <= '0;
            rd_cnt   <= '0;
            rd_data  <= '0;
            rd_resp  <= '0;
        end else begin
            rd_state <= rd_state_n;
            rd_addr  <= rd_addr_n;
            rd_cnt   <= rd_cnt_n;
            rd_data  <= rd_data_n;
            rd_resp  <= rd_resp_n;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_addr_n  = rd_addr;
        rd_cnt_n   = rd_cnt;
        rd_data_n  = rd_data;
        rd_resp_n  = rd_resp;
        case (rd_state)
            RD_IDLE: begin
                if (axi.ar_valid) begin
                    rd_addr_n = axi.ar_addr;
                    if (is_misaligned(axi.ar_addr)) begin
                        rd_data_n  = '0;
                        rd_resp_n  = RESP_SLVERR;
                        rd_state_n = RD_RESP;
                    end else begin
                        rd_state_n = RD_MEM;
                    end
                end
            end
            RD_MEM: begin
                rd_cnt_n   = CNT_WIDTH'(RD_LATENCY);
                rd_state_n = RD_WAIT;
            end
            RD_WAIT: begin
                // The count reaches 1 in the cycle RD_LATENCY after the strobe,
                // which is when the memory presents its data.
                if (rd_cnt == CNT_WIDTH'(1)) begin
                    rd_data_n  = iRdData;
                    rd_resp_n  = iRdResp;
                    rd_state_n = RD_RESP;
                end else begin
                    rd_cnt_n = rd_cnt - CNT_WIDTH'(1);
                end
            end
            RD_RESP: begin
                if (axi.r_ready) begin
                    rd_state_n = RD_IDLE;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    assign axi.ar_ready = (rd_state == RD_IDLE);
    assign axi.r_valid  = (rd_state == RD_RESP);
    assign axi.r_data   = rd_data;
    assign axi.r_resp   = rd_resp;
    assign oRdEn        = (rd_state == RD_MEM);
    assign oRdAddr      = rd_addr;

    // --------------------------------------------------------------- write engine
    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;

    wr_state_t               wr_state, wr_state_n;
    logic                    aw_held, aw_held_n;
    logic                    w_held, w_held_n;
    logic [ADDR_WIDTH-1:0]   wr_addr, wr_addr_n;
    logic [DATA_WIDTH-1:0]   wr_data, wr_data_n;
    logic [STRB_WIDTH-1:0]   wr_mask, wr_mask_n;
    logic [1:0]              b_resp, b_resp_n;
    logic                    aw_ready, w_ready;

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            wr_state <= WR_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_mask  <= '0;
            b_resp   <= '0;
        end else begin
            wr_state <= wr_state_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            wr_mask  <= wr_mask_n;
            b_resp   <= b_resp_n;
        end
    end

    // Each channel closes its own ready once its beat is held, so AW and W can
    // arrive in either order and the first one simply waits for its partner.
    assign aw_ready = (wr_state == WR_IDLE) && !aw_held;
    assign w_ready  = (wr_state == WR_IDLE) && !w_held;

    always_comb begin
        wr_state_n = wr_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        wr_addr_n  = wr_addr;
        wr_data_n  = wr_data;
        wr_mask_n  = wr_mask;
        b_resp_n   = b_resp;
        case (wr_state)
            WR_IDLE: begin
                if (axi.aw_valid && aw_ready) begin
                    wr_addr_n = axi.aw_addr;
                    aw_held_n = 1'b1;
                end
                if (axi.w_valid && w_ready) begin
                    wr_data_n = axi.w_data;
                    wr_mask_n = axi.w_strb;
                    w_held_n  = 1'b1;
                end
                if (aw_held_n && w_held_n) begin
                    wr_state_n = WR_EXEC;
                end
            end
            WR_EXEC: begin
                b_resp_n   = is_misaligned(wr_addr) ? RESP_SLVERR : iWrResp;
                aw_held_n  = 1'b0;
                w_held_n   = 1'b0;
                wr_state_n = WR_RESP;
            end
            WR_RESP: begin
                if (axi.b_ready) begin
                    wr_state_n = WR_IDLE;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end

    assign axi.aw_ready = aw_ready;
    assign axi.w_ready  = w_ready;
    assign axi.b_valid  = (wr_state == WR_RESP);
    assign axi.b_resp   = b_resp;
    assign oWrEn        = (wr_state == WR_EXEC) && !is_misaligned(wr_addr);
    assign oWrAddr      = wr_addr;
    assign oWrData      = wr_data;
    assign oWrMask      = wr_mask;
endmodule

// File: tb/tb_axi4_lite_slave_mem_if.sv
// tb/tb_axi4_lite_slave_mem_if.sv - scoreboard testbench for axi4_lite_slave_mem_if
module tb_axi4_lite_slave_mem_if;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 3;

    typedef struct { logic [31:0] addr; int cyc; } a_item_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; int cyc; } w_item_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en, wr_en;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data;
    logic [1:0]  rd_resp, wr_resp;
    logic [3:0]  wr_mask;

    int cyc = 0;
    int n_checks = 0;
    int n_err = 0;
    int p_rr = 100;
    int p_br = 100;
    int rd_due = -1;
    logic [31:0] rd_due_addr = '0;
    int last_rd_en_cyc = -1;
    int last_wr_en_cyc = -2;
    int rd_strobes = 0;
    int wr_strobes = 0;

    a_item_t rd_q[$];
    a_item_t aw_q[$];
    w_item_t w_q[$];

    axi4_lite_slave_mem_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    axi4_lite_slave_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .iClock (clk),
        .iReset (rst_n),
        .axi    (bus),
        .oRdEn  (rd_en),
        .oRdAddr(rd_addr),
        .iRdData(rd_data),
        .iRdResp(rd_resp),
        .oWrEn  (wr_en),
        .oWrAddr(wr_addr),
        .oWrData(wr_data),
        .oWrMask(wr_mask),
        .iWrResp(wr_resp)
    );

    // Reference memory contents and status codes, all pure functions of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction
    function automatic logic [1:0] rd_resp_fn(input logic [31:0] a);
        return a[5:4];
    endfunction
    function automatic logic [1:0] wr_resp_fn(input logic [31:0] a);
        return a[7:6];
    endfunction
    function automatic bit misal(input logic [31:0] a);
        return a[1:0] != 2'b00;
    endfunction

    assign wr_resp = wr_en ? wr_resp_fn(wr_addr) : 2'b01;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: correct data only in the cycle LAT after the strobe, junk otherwise.
    initial begin
        rd_data = '0;
        rd_resp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc == rd_due) begin
                rd_data = mem_word(rd_due_addr);
                rd_resp = rd_resp_fn(rd_due_addr);
            end else begin
                rd_data = $urandom;
                rd_resp = 2'($urandom);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.r_ready = ($urandom_range(99) < p_rr);
        bus.b_ready = ($urandom_range(99) < p_br);
    end

    // Monitor / scoreboard.
    initial begin : monitor
        a_item_t ai;
        w_item_t wi;
        int t;
        logic prev_rv, prev_bv, prev_r_stall, prev_b_stall, prev_r_hs, prev_b_hs;
        logic [31:0] prev_rdata;
        logic [1:0]  prev_rresp, prev_bresp;
        prev_rv = 0; prev_bv = 0; prev_r_stall = 0; prev_b_stall = 0;
        prev_r_hs = 0; prev_b_hs = 0; prev_rdata = '0; prev_rresp = '0; prev_bresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_rv = 0; prev_bv = 0; prev_r_stall = 0; prev_b_stall = 0;
                prev_r_hs = 0; prev_b_hs = 0;
            end else begin
                // ---- read side
                if (prev_r_stall) begin
                    chk("r_hold_valid", 32'(bus.r_valid), 1);
                    chk("r_hold_data", bus.r_data, prev_rdata);
                    chk("r_hold_resp", 32'(bus.r_resp), 32'(prev_rresp));
                end
                if (prev_r_hs) chk("ar_ready_after_r", 32'(bus.ar_ready), 1);
                if (rd_q.size() != 0) chk("ar_ready_busy", 32'(bus.ar_ready), 0);
                if (rd_en) begin
                    last_rd_en_cyc = cyc;
                    chk("rd_strobe_pending", rd_q.size(), 1);
                    if (rd_q.size() != 0) begin
                        chk("rd_strobe_addr", rd_addr, rd_q[0].addr);
                        chk("rd_strobe_aligned", 32'(misal(rd_q[0].addr)), 0);
                        chk("rd_strobe_time", cyc, rd_q[0].cyc + 1);
                        rd_strobes++;
                    end
                    rd_due = cyc + LAT;
                    rd_due_addr = rd_addr;
                end
                if (bus.r_valid && !prev_rv) begin
                    chk("r_valid_pending", rd_q.size(), 1);
                    if (rd_q.size() != 0) begin
                        t = misal(rd_q[0].addr) ? 1 : LAT + 2;
                        chk("r_valid_time", cyc, rd_q[0].cyc + t);
                    end
                end
                if (bus.r_valid && bus.r_ready && rd_q.size() != 0) begin
                    ai = rd_q.pop_front();
                    chk("r_data", bus.r_data, misal(ai.addr) ? 32'h0 : mem_word(ai.addr));
                    chk("r_resp", 32'(bus.r_resp), 32'(misal(ai.addr) ? 2'b10 : rd_resp_fn(ai.addr)));
                    chk("rd_strobe_count", rd_strobes, misal(ai.addr) ? 0 : 1);
                    rd_strobes = 0;
                end
                prev_r_stall = bus.r_valid && !bus.r_ready;
                prev_rdata   = bus.r_data;
                prev_rresp   = bus.r_resp;
                prev_rv      = bus.r_valid;
                prev_r_hs    = bus.r_valid && bus.r_ready;
                if (bus.ar_valid && bus.ar_ready) rd_q.push_back('{bus.ar_addr, cyc});

                // ---- write side
                if (prev_b_stall) begin
                    chk("b_hold_valid", 32'(bus.b_valid), 1);
                    chk("b_hold_resp", 32'(bus.b_resp), 32'(prev_bresp));
                end
                if (prev_b_hs) begin
                    chk("aw_ready_after_b", 32'(bus.aw_ready), 1);
                    chk("w_ready_after_b", 32'(bus.w_ready), 1);
                end
                if (aw_q.size() != 0) chk("aw_ready_busy", 32'(bus.aw_ready), 0);
                if (w_q.size() != 0) chk("w_ready_busy", 32'(bus.w_ready), 0);
                if (wr_en) begin
                    last_wr_en_cyc = cyc;
                    chk("wr_strobe_pending", (aw_q.size() != 0 && w_q.size() != 0) ? 1 : 0, 1);
                    if (aw_q.size() != 0 && w_q.size() != 0) begin
                        t = (aw_q[0].cyc > w_q[0].cyc) ? aw_q[0].cyc : w_q[0].cyc;
                        chk("wr_strobe_addr", wr_addr, aw_q[0].addr);
                        chk("wr_strobe_data", wr_data, w_q[0].data);
                        chk("wr_strobe_mask", 32'(wr_mask), 32'(w_q[0].strb));
                        chk("wr_strobe_aligned", 32'(misal(aw_q[0].addr)), 0);
                        chk("wr_strobe_time", cyc, t + 1);
                        wr_strobes++;
                    end
                end
                if (bus.b_valid && !prev_bv) begin
                    chk("b_valid_pending", (aw_q.size() != 0 && w_q.size() != 0) ? 1 : 0, 1);
                    if (aw_q.size() != 0 && w_q.size() != 0) begin
                        t = (aw_q[0].cyc > w_q[0].cyc) ? aw_q[0].cyc : w_q[0].cyc;
                        chk("b_valid_time", cyc, t + 2);
                    end
                end
                if (bus.b_valid && bus.b_ready && aw_q.size() != 0 && w_q.size() != 0) begin
                    ai = aw_q.pop_front();
                    wi = w_q.pop_front();
                    chk("b_resp", 32'(bus.b_resp), 32'(misal(ai.addr) ? 2'b10 : wr_resp_fn(ai.addr)));
                    chk("wr_strobe_count", wr_strobes, misal(ai.addr) ? 0 : 1);
                    wr_strobes = 0;
                end
                prev_b_stall = bus.b_valid && !bus.b_ready;
                prev_bresp   = bus.b_resp;
                prev_bv      = bus.b_valid;
                prev_b_hs    = bus.b_valid && bus.b_ready;
                if (bus.aw_valid && bus.aw_ready) aw_q.push_back('{bus.aw_addr, cyc});
                if (bus.w_valid && bus.w_ready) w_q.push_back('{bus.w_data, bus.w_strb, cyc});
            end
        end
    end

    // ---- stimulus drivers (all start and end just after a rising edge)
    task automatic do_read(input logic [31:0] a);
        int n = 0;
        bus.ar_addr  = a;
        bus.ar_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.ar_ready || n >= 200) break;
            n++;
        end
        chk("ar_accepted", 32'(bus.ar_ready), 1);
        tick();
        bus.ar_valid = 1'b0;
        bus.ar_addr  = $urandom;
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n = 0;
        bus.aw_addr  = a;
        bus.aw_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.aw_ready || n >= 200) break;
            n++;
        end
        chk("aw_accepted", 32'(bus.aw_ready), 1);
        tick();
        bus.aw_valid = 1'b0;
        bus.aw_addr  = $urandom;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bus.w_data  = d;
        bus.w_strb  = s;
        bus.w_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (bus.w_ready || n >= 200) break;
            n++;
        end
        chk("w_accepted", 32'(bus.w_ready), 1);
        tick();
        bus.w_valid = 1'b0;
        bus.w_data  = $urandom;
    endtask

    task automatic wait_idle();
        int n = 0;
        bit idle = 0;
        while (n < 1000 && !idle) begin
            @(negedge clk);
            idle = rd_q.size() == 0 && aw_q.size() == 0 && w_q.size() == 0 &&
                   !bus.ar_valid && !bus.aw_valid && !bus.w_valid &&
                   !bus.r_valid && !bus.b_valid;
            n++;
        end
        chk("drain_done", 32'(idle), 1);
        tick();
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ar_ready", 32'(bus.ar_ready), 1);
        chk("rst_aw_ready", 32'(bus.aw_ready), 1);
        chk("rst_w_ready", 32'(bus.w_ready), 1);
        chk("rst_r_valid", 32'(bus.r_valid), 0);
        chk("rst_b_valid", 32'(bus.b_valid), 0);
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_r_data", bus.r_data, 0);
        chk("rst_r_resp", 32'(bus.r_resp), 0);
        chk("rst_b_resp", 32'(bus.b_resp), 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_mask", 32'(wr_mask), 0);
    endtask

    initial begin : main
        logic [31:0] a;
        bus.ar_valid = 0; bus.ar_addr = '0;
        bus.aw_valid = 0; bus.aw_addr = '0;
        bus.w_valid = 0; bus.w_data = '0; bus.w_strb = '0;
        bus.r_ready = 1; bus.b_ready = 1;
        repeat (3) tick();
        chk_reset_outputs();
        rst_n = 1'b1;
        repeat (2) tick();

        // Aligned read, latency and data through the memory model.
        do_read(32'h8000_0004);
        wait_idle();

        // Read held in RD_RESP for 3 cycles by r_ready low.
        p_rr = 0;
        do_read(32'h0000_0130);
        begin
            int n = 0;
            while (!bus.r_valid && n < 50) begin @(negedge clk); n++; end
            chk("r_valid_seen", 32'(bus.r_valid), 1);
        end
        tick();
        repeat (2) tick();
        p_rr = 100;
        wait_idle();

        // W first, AW four cycles later.
        fork
            do_w(32'h1234_5678, 4'hF);
            begin repeat (4) tick(); do_aw(32'h10); end
        join
        wait_idle();

        // Misaligned write and read.
        fork
            do_aw(32'h13);
            do_w(32'hCAFE_F00D, 4'h3);
        join
        wait_idle();
        do_read(32'h2);
        wait_idle();

        // Concurrent read and write in the same cycle.
        last_rd_en_cyc = -1;
        last_wr_en_cyc = -2;
        fork
            do_read(32'h0000_0240);
            do_aw(32'h0000_00C8);
            do_w(32'hA5A5_1234, 4'h9);
        join
        wait_idle();
        chk("concurrent_strobes", last_rd_en_cyc, last_wr_en_cyc);

        // Randomized concurrent traffic with random back-pressure.
        p_rr = 60;
        p_br = 60;
        fork
            for (int i = 0; i < 30; i++) begin
                a = $urandom & 32'h0000_0FFC;
                if ($urandom_range(3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                repeat ($urandom_range(3)) tick();
                do_read(a);
            end
            for (int i = 0; i < 30; i++) begin
                logic [31:0] wa;
                wa = $urandom & 32'h0000_0FFC;
                if ($urandom_range(3) == 0) wa[1:0] = 2'($urandom_range(1, 3));
                repeat ($urandom_range(4)) tick();
                do_aw(wa);
            end
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(4)) tick();
                do_w($urandom, 4'($urandom));
            end
        join
        p_rr = 100;
        p_br = 100;
        wait_idle();

        // Reset while the read is in RD_WAIT and the write sits in WR_RESP.
        p_br = 0;
        fork
            do_read(32'h0000_0040);
            do_aw(32'h0000_0044);
            do_w(32'h0BAD_BEEF, 4'hF);
        join
        tick();
        #2;
        rst_n = 1'b0;
        rd_q.delete();
        aw_q.delete();
        w_q.delete();
        rd_due = -1;
        rd_strobes = 0;
        wr_strobes = 0;
        #1;
        chk_reset_outputs();
        tick();
        tick();
        chk_reset_outputs();
        p_br = 100;
        rst_n = 1'b1;
        repeat (8) tick();
        do_read(32'h0000_0350);
        wait_idle();
        chk("rd_q_empty", rd_q.size(), 0);
        chk("aw_q_empty", aw_q.size(), 0);
        chk("w_q_empty", w_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        n_checks++;
        n_err++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
